dp_sequencer: RTL and testbench
===============================

DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL use these parameters: XLEN, 32, data/address width; FEED_GAP, 4, minimum cycles between consecutive feeder weight strobes (at least the FP adder latency); TIMEOUT_CYCLES, 1024, watchdog limit.
REQ-002 The block SHALL use one clock, clk_i; reset is rst_ni, asynchronous and active-low.
REQ-003 The block SHALL provide these ports: clk_i in 1 clock; rst_ni in 1 async active-low reset.
REQ-004 The block SHALL provide cfg_we_i in 1 and cfg_addr_i in 3 (register word index): register write strobe and index.
REQ-005 The block SHALL provide cfg_wdata_i in XLEN and cfg_rdata_o out XLEN: register write data and combinational read data.
REQ-006 The block SHALL provide mem_req_o out 1, mem_we_o out 1 and mem_addr_o out XLEN: memory request, write enable and word-aligned address.
REQ-007 The block SHALL provide mem_wdata_o out XLEN, mem_ack_i in 1 and mem_rdata_i in XLEN: memory write data, acknowledge (one cycle) and read data.
REQ-008 The block SHALL provide fd_strobe_o out 1, fd_rw_o out 1, fd_addr_o out XLEN and fd_data_o out XLEN: data-feeder strobe, direction (1 = write), address and write data.
REQ-009 The block SHALL provide fd_ready_i in 1 and fd_data_i in XLEN: feeder result ready and result.
REQ-010 The block SHALL provide busy_o out 1 (job running) and irq_o out 1 (one-cycle pulse when a job completes).

Function
REQ-011 The block SHALL map registers by index: 0 SIZE, the vector length without bias; 1 NEURONS; 2 WBASE, the weight base; 3 RBASE, the result base; 4 CTRL, where bit0 start and bit1 abort self-clear; 5 STATUS (read-only), where bit0 busy, bit1 done, bit2 timeout, and done and timeout are cleared by a start.
REQ-012 The state machine SHALL run IDLE -> SETSZ -> FETCH -> FEED -> GAP -> (FETCH | RDRES) -> WRES -> (FETCH | IDLE).
REQ-013 In SETSZ, the block SHALL issue one fd_strobe_o write to 0xC400_3000 with data SIZE, then go to FETCH.
REQ-014 In FETCH, the block SHALL hold mem_req_o=1 and mem_we_o=0 at the weight pointer until mem_ack_i; it SHALL capture mem_rdata_i.
REQ-015 In FEED, the block SHALL assert one fd_strobe_o write to 0xC400_1000 for one cycle; the weight pointer SHALL increment by 4.
REQ-016 GAP SHALL last FEED_GAP-1 cycles, counted from the strobe; after SIZE+1 feeds for the neuron (bias included) the block SHALL go to RDRES, otherwise to FETCH.
REQ-017 In RDRES, the block SHALL hold fd_rw_o=0 and fd_addr_o=0xC400_2000 until fd_ready_i, then latch fd_data_i.
REQ-018 In WRES, the block SHALL write the latched result to RBASE+4*n and wait for mem_ack_i; n SHALL increment, and when n==NEURONS the block SHALL pulse irq_o, set done and return to IDLE.
REQ-019 Weights SHALL be read contiguously: the neuron n, element k address is WBASE+4*(n*(SIZE+1)+k), produced by a running pointer (no multiplier).
REQ-020 Start with NEURONS==0 SHALL set done and pulse irq_o in the next cycle, with no feeder or memory traffic.
REQ-021 Register writes other than abort SHALL be ignored while busy; start while busy SHALL be ignored.
REQ-022 Abort SHALL return the block to IDLE in the next cycle without pulsing irq_o or setting done; an in-flight mem_req_o SHALL be dropped.
REQ-023 The block SHALL never assert fd_strobe_o and mem_req_o in the same cycle.
REQ-024 Counters SHALL be XLEN wide; pointer arithmetic SHALL wrap modulo 2^XLEN without error.

Reset
REQ-025 On rst_ni low, all outputs SHALL be 0, all registers 0 and the state IDLE, asynchronously; deassertion SHALL be synchronous to clk_i.
REQ-026 Reset mid-job SHALL abandon the job, with no irq_o pulse after release.

Configuration
REQ-027 With SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles in FETCH, RDRES and WRES; reaching TIMEOUT_CYCLES SHALL set the timeout bit, pulse irq_o and return to IDLE.
REQ-028 Without SEQ_TIMEOUT_EN, there SHALL be no watchdog logic, the timeout bit SHALL read 0, and waits SHALL be unbounded.

Structure
REQ-029 The package dp_seq_pkg SHALL hold the state enum, register index constants, the feeder addresses (0xC400_1000, 0xC400_2000, 0xC400_3000) and the STATUS bit positions.
REQ-030 The block SHALL have one sub-module, dp_seq_regfile, holding the register storage, read mux and CTRL self-clear.

Verification
REQ-031 Scenario: SIZE=2, NEURONS=1, WBASE=0x100, RBASE=0x200, start -> one write to 0x3000 with data 2; reads at 0x100, 0x104, 0x108; three 0x1000 strobes, at least 4 cycles apart; one 0x2000 read; a write to 0x200; one irq_o pulse.
REQ-032 Scenario: NEURONS=3, SIZE=1 -> weight reads at 0x100–0x114 contiguous; result writes at 0x200, 0x204, 0x208; irq_o after the third write only.
REQ-033 Scenario: NEURONS=0 start -> irq_o one cycle later; done=1; zero strobes.
REQ-034 Scenario: abort during GAP of the second feed -> IDLE next cycle; no further strobes; no irq_o; done=0.
REQ-035 Scenario (SEQ_TIMEOUT_EN): fd_ready_i held 0 -> timeout bit=1 and irq_o exactly TIMEOUT_CYCLES cycles after entering RDRES.
REQ-036 Scenario: rst_ni pulsed low mid-FETCH -> all outputs 0 immediately; STATUS=0 after release.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared definitions for dp_sequencer: FSM state codes, register map, feeder addresses
// and STATUS layout. The optional watchdog is enabled by defining SEQ_TIMEOUT_EN.
package dp_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETSZ = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_FEED  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_RDRES = 3'd5;
    localparam logic [2:0] ST_WRES  = 3'd6;

    localparam logic [2:0] REG_SIZE    = 3'd0;
    localparam logic [2:0] REG_NEURONS = 3'd1;
    localparam logic [2:0] REG_WBASE   = 3'd2;
    localparam logic [2:0] REG_RBASE   = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;

    localparam logic [31:0] FD_ADDR_WEIGHT = 32'hC400_1000;
    localparam logic [31:0] FD_ADDR_RESULT = 32'hC400_2000;
    localparam logic [31:0] FD_ADDR_SIZE   = 32'hC400_3000;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_ABORT_BIT   = 1;
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;

    // Field order gives busy at bit 0, done at bit 1, timeout at bit 2.
    typedef struct packed {
        logic timeout;
        logic done;
        logic busy;
    } status_t;

endpackage

// File: rtl/dp_seq_regfile.sv
// Configuration registers for dp_sequencer: storage, combinational read mux, and the
// self-clearing CTRL start/abort pulses (CTRL always reads back as zero).
module dp_seq_regfile
    import dp_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    input  logic            busy,
    input  logic            done,
    input  logic            timeout,
    output logic [XLEN-1:0] size,
    output logic [XLEN-1:0] neurons,
    output logic [XLEN-1:0] wbase,
    output logic [XLEN-1:0] rbase,
    output logic            start,
    output logic            abort,
    output logic [XLEN-1:0] rdata
);

    logic    wr_ok;
    status_t status;

    // Only abort gets through while a job runs; everything else is frozen.
    assign wr_ok  = cfg_we && !busy;
    assign start  = wr_ok && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_START_BIT];
    assign abort  = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_ABORT_BIT];
    assign status = '{timeout: timeout, done: done, busy: busy};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            size    <= '0;
            neurons <= '0;
            wbase   <= '0;
            rbase   <= '0;
        end else if (wr_ok) begin
            case (cfg_addr)
                REG_SIZE:    size    <= cfg_wdata;
                REG_NEURONS: neurons <= cfg_wdata;
                REG_WBASE:   wbase   <= cfg_wdata;
                REG_RBASE:   rbase   <= cfg_wdata;
                default:     ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (cfg_addr)
            REG_SIZE:    rdata = size;
            REG_NEURONS: rdata = neurons;
            REG_WBASE:   rdata = wbase;
            REG_RBASE:   rdata = rbase;
            REG_STATUS:  rdata = XLEN'(status);
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// Dot-product job sequencer: streams weights from memory into the FP feeder, reads back
// one result per neuron and stores it. Define SEQ_TIMEOUT_EN to add the wait watchdog.
module dp_sequencer
    import dp_seq_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int FEED_GAP       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_we_i,
    input  logic [2:0]      cfg_addr_i,
    input  logic [XLEN-1:0] cfg_wdata_i,
    output logic [XLEN-1:0] cfg_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            fd_strobe_o,
    output logic            fd_rw_o,
    output logic [XLEN-1:0] fd_addr_o,
    output logic [XLEN-1:0] fd_data_o,
    input  logic            fd_ready_i,
    input  logic [XLEN-1:0] fd_data_i,
    output logic            busy_o,
    output logic            irq_o,
    output logic [2:0]      state_o
);

    logic [2:0]      state_q;
    logic [XLEN-1:0] size, neurons, wbase, rbase;
    logic [XLEN-1:0] wptr_q, rptr_q, n_q, k_q, gap_q, weight_q, result_q;
    logic            start, abort, busy, done_q, irq_q, timeout_bit;

    assign busy = (state_q != ST_IDLE);

    dp_seq_regfile #(.XLEN(XLEN)) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .cfg_we    (cfg_we_i),
        .cfg_addr  (cfg_addr_i),
        .cfg_wdata (cfg_wdata_i),
        .busy      (busy),
        .done      (done_q),
        .timeout   (timeout_bit),
        .size      (size),
        .neurons   (neurons),
        .wbase     (wbase),
        .rbase     (rbase),
        .start     (start),
        .abort     (abort),
        .rdata     (cfg_rdata_o)
    );

    // Handshakes: mem_req_o is held with stable address/data until the single-cycle
    // mem_ack_i; a feeder result read holds fd_addr_o until fd_ready_i; strobes are one cycle.
`ifdef SEQ_TIMEOUT_EN
    logic            timeout_q, waiting, wd_fire;
    logic [XLEN-1:0] wd_q;

    assign waiting = ((state_q == ST_FETCH || state_q == ST_WRES) && !mem_ack_i) ||
                     ((state_q == ST_RDRES) && !fd_ready_i);
    assign wd_fire = waiting && (wd_q == XLEN'(TIMEOUT_CYCLES - 1));
    assign timeout_bit = timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= (waiting && !wd_fire && !abort) ? wd_q + XLEN'(1) : '0;
            if (start)
                timeout_q <= 1'b0;
            else if (wd_fire && !abort)
                timeout_q <= 1'b1;
        end
    end
`else
    // No watchdog: the flag can never set for any legal limit.
    assign timeout_bit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            n_q      <= '0;
            k_q      <= '0;
            gap_q    <= '0;
            weight_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (abort && busy) begin
                state_q <= ST_IDLE;
`ifdef SEQ_TIMEOUT_EN
            end else if (wd_fire) begin
                state_q <= ST_IDLE;
                irq_q   <= 1'b1;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        done_q <= 1'b0;
                        wptr_q <= wbase;
                        rptr_q <= rbase;
                        n_q    <= '0;
                        k_q    <= '0;
                        if (neurons == '0) begin
                            done_q <= 1'b1;
                            irq_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SETSZ;
                        end
                    end
                    ST_SETSZ: state_q <= ST_FETCH;
                    ST_FETCH: if (mem_ack_i) begin
                        weight_q <= mem_rdata_i;
                        state_q  <= ST_FEED;
                    end
                    ST_FEED: begin
                        wptr_q  <= wptr_q + XLEN'(4);
                        k_q     <= k_q + XLEN'(1);
                        gap_q   <= XLEN'(1);
                        state_q <= ST_GAP;
                    end
                    // gap_q counts cycles since the strobe; k_q already includes the bias feed.
                    ST_GAP: begin
                        if (gap_q >= XLEN'(FEED_GAP - 1))
                            state_q <= (k_q == size + XLEN'(1)) ? ST_RDRES : ST_FETCH;
                        else
                            gap_q <= gap_q + XLEN'(1);
                    end
                    ST_RDRES: if (fd_ready_i) begin
                        result_q <= fd_data_i;
                        state_q  <= ST_WRES;
                    end
                    ST_WRES: if (mem_ack_i) begin
                        rptr_q <= rptr_q + XLEN'(4);
                        n_q    <= n_q + XLEN'(1);
                        k_q    <= '0;
                        if (n_q + XLEN'(1) == neurons) begin
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_req_o   = (state_q == ST_FETCH) || (state_q == ST_WRES);
    assign mem_we_o    = (state_q == ST_WRES);
    assign mem_addr_o  = (state_q == ST_FETCH) ? wptr_q :
                         (state_q == ST_WRES)  ? rptr_q : '0;
    assign mem_wdata_o = (state_q == ST_WRES) ? result_q : '0;
    assign fd_strobe_o = (state_q == ST_SETSZ) || (state_q == ST_FEED);
    assign fd_rw_o     = fd_strobe_o;
    assign fd_addr_o   = (state_q == ST_SETSZ) ? XLEN'(FD_ADDR_SIZE)   :
                         (state_q == ST_FEED)  ? XLEN'(FD_ADDR_WEIGHT) :
                         (state_q == ST_RDRES) ? XLEN'(FD_ADDR_RESULT) : '0;
    assign fd_data_o   = (state_q == ST_SETSZ) ? size :
                         (state_q == ST_FEED)  ? weight_q : '0;
    assign busy_o      = busy;
    assign irq_o       = irq_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: random jobs against a queue-based model of the
// expected memory and feeder traffic, plus directed abort, reset and zero-neuron cases.
`timescale 1ns/1ps
module tb_dp_sequencer;

    localparam int XLEN           = 32;
    localparam int FEED_GAP       = 4;
    localparam int TIMEOUT_CYCLES = 1024;
    localparam logic [31:0] FD_W = 32'hC400_1000;
    localparam logic [31:0] FD_R = 32'hC400_2000;
    localparam logic [31:0] FD_S = 32'hC400_3000;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cfg_we_i = 1'b0;
    logic [2:0]      cfg_addr_i = '0;
    logic [31:0]     cfg_wdata_i = '0;
    logic [31:0]     cfg_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [31:0]     mem_addr_o, mem_wdata_o;
    logic            mem_ack_i = 1'b0;
    logic [31:0]     mem_rdata_i = '0;
    logic            fd_strobe_o, fd_rw_o;
    logic [31:0]     fd_addr_o, fd_data_o;
    logic            fd_ready_i = 1'b0;
    logic [31:0]     fd_data_i = '0;
    logic            busy_o, irq_o;
    logic [2:0]      state_o;

    always #5 clk_i = ~clk_i;

    dp_sequencer #(.XLEN(XLEN), .FEED_GAP(FEED_GAP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .fd_strobe_o(fd_strobe_o), .fd_rw_o(fd_rw_o), .fd_addr_o(fd_addr_o),
        .fd_data_o(fd_data_o), .fd_ready_i(fd_ready_i), .fd_data_i(fd_data_i),
        .busy_o(busy_o), .irq_o(irq_o), .state_o(state_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected traffic for the running job
    logic [31:0] exp_rd_q[$];
    logic [63:0] exp_st_q[$];
    logic [31:0] exp_wr_q[$];
    logic [31:0] res_q[$];

    int  cyc = 0, mem_wait = 0, fd_wait = 0;
    int  st_cnt = 0, mem_cnt = 0, fd_rd_cnt = 0, conflict_cnt = 0;
    int  irq_cnt = 0, irq_dbl = 0, last_irq_cyc = 0, last_wr_ack_cyc = 0;
    int  feed_prev = -1, rd_enter_cyc = 0;
    int  job_irq0 = 0, job_rd0 = 0, job_conf0 = 0;
    bit  chk_en = 1'b0, fd_hold = 1'b0, irq_prev = 1'b0, rd_prev = 1'b0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Monitor and responders: sample 1ns after the edge, answer for the next edge
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            mem_ack_i  = 1'b0;
            fd_ready_i = 1'b0;
            if (irq_o) begin
                irq_cnt++;
                last_irq_cyc = cyc;
                if (irq_prev) irq_dbl++;
            end
            irq_prev = irq_o;
            if (fd_strobe_o && mem_req_o) conflict_cnt++;
            if (fd_strobe_o) begin
                st_cnt++;
                if (chk_en) begin
                    if (exp_st_q.size() == 0) check("strobe_extra", {fd_addr_o, fd_data_o}, 64'd0);
                    else check("strobe", {fd_addr_o, fd_data_o}, exp_st_q.pop_front());
                    check("strobe_rw", fd_rw_o, 1);
                end
                if (fd_addr_o == FD_W) begin
                    if (feed_prev >= 0) check("feed_gap", (cyc - feed_prev) >= FEED_GAP, 1);
                    feed_prev = cyc;
                end
            end
            if (mem_req_o) begin
                if (mem_wait == 0) begin
                    mem_ack_i = 1'b1;
                    mem_cnt++;
                    mem_wait = $urandom_range(0, 3);
                    if (mem_we_o) begin
                        last_wr_ack_cyc = cyc;
                        if (chk_en) begin
                            if (exp_wr_q.size() == 0) check("wr_extra", 1, 0);
                            else check("wr_addr", mem_addr_o, exp_wr_q.pop_front());
                            if (res_q.size() == 0) check("wr_nores", 1, 0);
                            else check("wr_data", mem_wdata_o, res_q.pop_front());
                        end
                    end else begin
                        mem_rdata_i = mem_val(mem_addr_o);
                        if (chk_en) begin
                            if (exp_rd_q.size() == 0) check("rd_extra", 1, 0);
                            else check("rd_addr", mem_addr_o, exp_rd_q.pop_front());
                        end
                    end
                end else begin
                    mem_wait--;
                end
            end
            if (busy_o && !fd_rw_o && fd_addr_o == FD_R) begin
                if (!rd_prev) rd_enter_cyc = cyc;
                rd_prev = 1'b1;
                if (!fd_hold) begin
                    if (fd_wait == 0) begin
                        fd_ready_i = 1'b1;
                        fd_data_i  = $urandom;
                        res_q.push_back(fd_data_i);
                        fd_rd_cnt++;
                        fd_wait = $urandom_range(0, 4);
                    end else begin
                        fd_wait--;
                    end
                end
            end else begin
                rd_prev = 1'b0;
            end
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk_i);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk_i);
        cfg_addr_i = a;
        #1;
        d = cfg_rdata_o;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {fd_strobe_o, fd_rw_o, mem_req_o, mem_we_o, busy_o, irq_o, state_o}, 0);
        check({tag, "_addr"}, {mem_addr_o, fd_addr_o}, 0);
        check({tag, "_data"}, {mem_wdata_o, fd_data_o}, 0);
        check({tag, "_rdata"}, cfg_rdata_o, 0);
    endtask

    // Model: contiguous weights at WBASE+4*(n*(SIZE+1)+k), one result per neuron at RBASE+4*n
    task automatic setup_job(input logic [31:0] size, input logic [31:0] neurons,
                             input logic [31:0] wbase, input logic [31:0] rbase);
        logic [31:0] idx, a;
        exp_rd_q.delete(); exp_st_q.delete(); exp_wr_q.delete(); res_q.delete();
        exp_st_q.push_back({FD_S, size});
        for (int n = 0; n < int'(neurons); n++) begin
            for (int k = 0; k <= int'(size); k++) begin
                idx = 32'(n) * (size + 32'd1) + 32'(k);
                a   = wbase + (idx << 2);
                exp_rd_q.push_back(a);
                exp_st_q.push_back({FD_W, mem_val(a)});
            end
            exp_wr_q.push_back(rbase + 32'd4 * 32'(n));
        end
        feed_prev = -1;
        cfg_write(3'd0, size);
        cfg_write(3'd1, neurons);
        cfg_write(3'd2, wbase);
        cfg_write(3'd3, rbase);
        job_irq0  = irq_cnt;
        job_rd0   = fd_rd_cnt;
        job_conf0 = conflict_cnt;
    endtask

    task automatic wait_irq(input int base, input int budget);
        int t;
        t = 0;
        while (irq_cnt == base && t < budget) begin
            @(posedge clk_i);
            #2;
            t++;
        end
        check("irq_seen", irq_cnt > base, 1);
    endtask

    task automatic finish_job(input logic [31:0] neurons);
        logic [31:0] st;
        wait_irq(job_irq0, 3000);
        repeat (3) @(posedge clk_i);
        check("rd_left", exp_rd_q.size(), 0);
        check("strobe_left", exp_st_q.size(), 0);
        check("wr_left", exp_wr_q.size(), 0);
        check("irq_count", irq_cnt - job_irq0, 1);
        check("irq_after_last_wr", last_irq_cyc - last_wr_ack_cyc, 1);
        check("fd_reads", fd_rd_cnt - job_rd0, neurons);
        check("no_strobe_mem_overlap", conflict_cnt - job_conf0, 0);
        cfg_read(3'd5, st);
        check("status_done", st, 32'd2);
    endtask

    task automatic run_job(input logic [31:0] size, input logic [31:0] neurons,
                           input logic [31:0] wbase, input logic [31:0] rbase);
        chk_en = 1'b1;
        setup_job(size, neurons, wbase, rbase);
        cfg_write(3'd4, 32'd1);
        finish_job(neurons);
    endtask

    initial begin
        logic [31:0] st;
        int s0, m0, i0, t;

        repeat (3) @(posedge clk_i);
        #1;
        check_outputs_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        cfg_read(3'd5, st);
        check("reset_status", st, 0);
        cfg_read(3'd0, st);
        check("reset_size", st, 0);

        run_job(32'd2, 32'd1, 32'h100, 32'h200);
        run_job(32'd1, 32'd3, 32'h100, 32'h200);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 3), $urandom_range(1, 3),
                    $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        run_job(32'd1, 32'd2, 32'hFFFF_FFF0, 32'hFFFF_FFFC);

        // Zero neurons: irq right after the start edge, no traffic at all
        s0 = st_cnt; m0 = mem_cnt; i0 = irq_cnt;
        cfg_write(3'd1, 32'd0);
        cfg_write(3'd4, 32'd1);
        check("n0_irq_next", irq_o, 1);
        check("n0_busy", busy_o, 0);
        cfg_read(3'd5, st);
        check("n0_status", st, 32'd2);
        check("n0_irq_width", irq_o, 0);
        repeat (5) @(posedge clk_i);
        check("n0_strobes", st_cnt - s0, 0);
        check("n0_mem", mem_cnt - m0, 0);
        check("n0_irq_count", irq_cnt - i0, 1);

        // Writes and a second start while busy are ignored
        chk_en = 1'b1;
        setup_job(32'd1, 32'd2, 32'h800, 32'h900);
        cfg_write(3'd4, 32'd1);
        cfg_write(3'd0, 32'd7);
        cfg_write(3'd4, 32'd1);
        cfg_read(3'd0, st);
        check("busy_size_kept", st, 32'd1);
        finish_job(32'd2);

        // Abort in the gap after the second weight strobe
        chk_en = 1'b0;
        setup_job(32'd2, 32'd1, 32'h300, 32'h400);
        s0 = st_cnt; i0 = irq_cnt;
        cfg_write(3'd4, 32'd1);
        t = 0;
        while (st_cnt - s0 < 3 && t < 200) begin
            @(posedge clk_i);
            #2;
            t++;
        end
        check("abort_reach_feed2", st_cnt - s0, 3);
        @(negedge clk_i);
        cfg_write(3'd4, 32'd2);
        check("abort_idle", busy_o, 0);
        check("abort_no_req", {mem_req_o, fd_strobe_o}, 0);
        repeat (30) @(posedge clk_i);
        check("abort_no_strobes", st_cnt - s0, 3);
        check("abort_no_irq", irq_cnt - i0, 0);
        cfg_read(3'd5, st);
        check("abort_status", st, 0);

        // Reset while a weight fetch is outstanding
        setup_job(32'd1, 32'd2, 32'h500, 32'h600);
        cfg_write(3'd4, 32'd1);
        t = 0;
        while (!(mem_req_o && !mem_we_o) && t < 200) begin
            @(posedge clk_i);
            #2;
            t++;
        end
        check("rst_reach_fetch", mem_req_o && !mem_we_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        i0 = irq_cnt;
        repeat (20) @(posedge clk_i);
        check("rst_mid_no_irq", irq_cnt - i0, 0);
        cfg_read(3'd5, st);
        check("rst_mid_status", st, 0);
        cfg_read(3'd1, st);
        check("rst_mid_neurons", st, 0);

`ifdef SEQ_TIMEOUT_EN
        // Feeder never answers: watchdog fires TIMEOUT_CYCLES after entering the result read
        fd_hold = 1'b1;
        setup_job(32'd0, 32'd1, 32'h700, 32'h780);
        cfg_write(3'd4, 32'd1);
        wait_irq(job_irq0, TIMEOUT_CYCLES + 200);
        check("wd_latency", last_irq_cyc - rd_enter_cyc, TIMEOUT_CYCLES);
        cfg_read(3'd5, st);
        check("wd_status", st, 32'd4);
        fd_hold = 1'b0;
`endif

        check("irq_single_cycle", irq_dbl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        check("global_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
